// File: rtl/letter_entry_encoder.sv
// Pushbutton front end for the hangman letter path: debounces three keys, scrolls a
// cursor letter (1..26), offers committed guesses over valid/ready and rejects repeats.
module letter_entry_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       guess_ready,
  output logic [4:0] letter_code,
  output logic [4:0] guess_code,
  output logic       guess_valid,
  output logic       dup_flag,
  output logic [4:0] guess_count
);

  localparam int                NUM_KEYS    = 3;
  localparam int                KEY_UP      = 0;
  localparam int                KEY_DOWN    = 1;
  localparam int                KEY_ENTER   = 2;
  localparam logic [CNT_W-1:0]  LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]        LP_FIRST    = 5'd1;
  localparam logic [4:0]        LP_LAST     = 5'd26;

  typedef enum logic {
    ST_SELECT = 1'b0,
    ST_OFFER  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchroniser, stability counter, press-edge detect
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_deb;
  logic [CNT_W-1:0]    r_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_flip;
  logic [NUM_KEYS-1:0] w_press;

  assign w_raw = {key_enter, key_down, key_up};

  // The press event fires in the same cycle the debounced level is about to rise,
  // so the cursor moves on the very edge the level is accepted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_flip  = '0;
    w_press = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_flip[i]  = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == LP_CNT_LAST);
      w_press[i] = w_flip[i] && r_sync2[i];
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      // NOTE: the counter array is small and must start from zero, so it is reset element by element.
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Letter selection / guess offer state machine
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_letter;
  logic [4:0]  w_letter_next;
  logic [4:0]  r_guess;
  logic [4:0]  w_guess_next;
  logic        r_valid;
  logic        w_valid_next;
  logic        r_dup;
  logic        w_dup_next;
  logic [4:0]  r_count;
  logic [4:0]  w_count_next;
  logic [31:0] r_used;
  logic [31:0] w_used_next;
  logic        w_step_up;
  logic        w_step_down;

  // Simultaneous up and down cancel each other.
  assign w_step_up   = w_press[KEY_UP]   && !w_press[KEY_DOWN];
  assign w_step_down = w_press[KEY_DOWN] && !w_press[KEY_UP];

  always_comb begin
    w_state_next  = r_state;
    w_letter_next = r_letter;
    w_guess_next  = r_guess;
    w_valid_next  = r_valid;
    w_dup_next    = 1'b0;
    w_count_next  = r_count;
    w_used_next   = r_used;

    if (new_game) begin
      w_state_next  = ST_SELECT;
      w_letter_next = LP_FIRST;
      w_valid_next  = 1'b0;
      w_count_next  = '0;
      w_used_next   = '0;
    end else begin
      unique case (r_state)
        ST_SELECT: begin
          if (w_press[KEY_ENTER]) begin
            if (r_used[r_letter]) begin
              w_dup_next = 1'b1;
            end else begin
              w_guess_next = r_letter;
              w_valid_next = 1'b1;
              w_state_next = ST_OFFER;
            end
          end else if (w_step_up) begin
            w_letter_next = (r_letter == LP_LAST) ? LP_FIRST : r_letter + 5'd1;
          end else if (w_step_down) begin
            w_letter_next = (r_letter == LP_FIRST) ? LP_LAST : r_letter - 5'd1;
          end
        end
        ST_OFFER: begin
          // Key events are dropped here; only the handshake moves the machine on.
          if (r_valid && guess_ready) begin
            w_valid_next         = 1'b0;
            w_used_next[r_guess] = 1'b1;
            w_count_next         = (r_count == LP_LAST) ? LP_LAST : r_count + 5'd1;
            w_state_next         = ST_SELECT;
          end
        end
        default: begin
          w_state_next = ST_SELECT;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_SELECT;
      r_letter <= LP_FIRST;
      r_guess  <= '0;
      r_valid  <= 1'b0;
      r_dup    <= 1'b0;
      r_count  <= '0;
      r_used   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_letter <= w_letter_next;
      r_guess  <= w_guess_next;
      r_valid  <= w_valid_next;
      r_dup    <= w_dup_next;
      r_count  <= w_count_next;
      r_used   <= w_used_next;
    end
  end

  assign letter_code = r_letter;
  assign guess_code  = r_guess;
  assign guess_valid = r_valid;
  assign dup_flag    = r_dup;
  assign guess_count = r_count;

endmodule

// File: tb/tb_letter_entry_encoder.sv
// Self-checking bench for letter_entry_encoder: directed scenarios plus random key
// traffic, all compared cycle by cycle against a sample-history reference model.
module tb_letter_entry_encoder;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       key_enter = 1'b0;
  logic       guess_ready = 1'b0;
  logic [4:0] letter_code;
  logic [4:0] guess_code;
  logic       guess_valid;
  logic       dup_flag;
  logic [4:0] guess_count;

  int n_checks = 0;
  int n_bad    = 0;

  letter_entry_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .new_game    (new_game),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_enter   (key_enter),
    .guess_ready (guess_ready),
    .letter_code (letter_code),
    .guess_code  (guess_code),
    .guess_valid (guess_valid),
    .dup_flag    (dup_flag),
    .guess_count (guess_count)
  );

  always #5 clock = ~clock;

  // Reference model: raw key samples per edge, the accepted key levels, and the game view.
  bit m_hist [3][0:D];
  bit m_deb  [3];
  int m_letter, m_guess, m_count;
  bit m_valid, m_dup;
  bit m_used [0:31];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the model. A key level is accepted once the last D synchronised
  // samples (taken two edges late) all disagree with the currently accepted level.
  task automatic model_step();
    bit raw [3];
    bit ev  [3];
    raw[0] = key_up;
    raw[1] = key_down;
    raw[2] = key_enter;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j <= D; j++) m_hist[k][j] = 1'b0;
        m_deb[k] = 1'b0;
      end
      for (int c = 0; c < 32; c++) m_used[c] = 1'b0;
      m_letter = 1; m_guess = 0; m_count = 0; m_valid = 0; m_dup = 0;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) if (m_hist[k][j] == m_deb[k]) all_diff = 1'b0;
      ev[k] = all_diff && !m_deb[k];
      if (all_diff) m_deb[k] = !m_deb[k];
      for (int j = D; j >= 1; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = raw[k];
    end
    m_dup = 1'b0;
    if (new_game) begin
      for (int c = 0; c < 32; c++) m_used[c] = 1'b0;
      m_count = 0; m_valid = 0; m_letter = 1;
    end else if (!m_valid) begin
      if (ev[2]) begin
        if (m_used[m_letter]) m_dup = 1'b1;
        else begin
          m_guess = m_letter;
          m_valid = 1'b1;
        end
      end else if (ev[0] && !ev[1]) begin
        m_letter = (m_letter % 26) + 1;
      end else if (ev[1] && !ev[0]) begin
        m_letter = (m_letter == 1) ? 26 : m_letter - 1;
      end
    end else if (guess_ready) begin
      m_valid = 1'b0;
      m_used[m_guess] = 1'b1;
      m_count = (m_count < 26) ? m_count + 1 : 26;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("letter_code", letter_code, m_letter);
    check("guess_code",  guess_code,  m_guess);
    check("guess_valid", guess_valid, m_valid);
    check("dup_flag",    dup_flag,    m_dup);
    check("guess_count", guess_count, m_count);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_up = v;
      1: key_down = v;
      default: key_enter = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    repeat (D + 4) tick();
    set_key(k, 1'b0);
    repeat (D + 4) tick();
  endtask

  initial begin
    // 1. reset
    reset = 1'b1;
    repeat (2) tick();
    check("rst_letter", letter_code, 1);
    check("rst_guess",  guess_code,  0);
    check("rst_valid",  guess_valid, 0);
    check("rst_dup",    dup_flag,    0);
    check("rst_count",  guess_count, 0);
    reset = 1'b0;
    tick();

    // 2. down at 1 wraps to 26 after exactly 2+D cycles, up wraps back
    key_down = 1'b1;
    repeat (D + 1) tick();
    check("down_early", letter_code, 1);
    tick();
    check("down_wrap", letter_code, 26);
    repeat (2) tick();
    key_down = 1'b0;
    repeat (D + 4) tick();
    press(0);
    check("up_wrap", letter_code, 1);

    // 3. short glitches are filtered
    repeat (5) begin
      key_up = 1'b1;
      repeat (3) tick();
      key_up = 1'b0;
      repeat (3) tick();
    end
    check("glitch_letter", letter_code, 1);

    // 4. commit 5 and hold the offer
    repeat (4) press(0);
    check("scroll_to_5", letter_code, 5);
    press(2);
    repeat (10) tick();
    press(0);
    check("offer_valid",  guess_valid, 1);
    check("offer_code",   guess_code,  5);
    check("offer_letter", letter_code, 5);
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("accept_valid", guess_valid, 0);
    check("accept_count", guess_count, 1);

    // 5. repeat guess flags a duplicate for one cycle only
    key_enter = 1'b1;
    repeat (D + 2) tick();
    check("dup_pulse", dup_flag, 1);
    check("dup_valid", guess_valid, 0);
    tick();
    check("dup_clear", dup_flag, 0);
    key_enter = 1'b0;
    repeat (D + 4) tick();
    check("dup_count", guess_count, 1);

    // 6. new_game abandons an offer and clears the mask
    press(0);
    press(2);
    check("pre_ng_valid", guess_valid, 1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng_valid",  guess_valid, 0);
    check("ng_count",  guess_count, 0);
    check("ng_letter", letter_code, 1);
    repeat (4) press(0);
    press(2);
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("ng_regs_code",  guess_code,  5);
    check("ng_regs_count", guess_count, 1);

    // Fill all 26 letters, then every enter is a duplicate
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    guess_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      press(2);
      press(0);
    end
    guess_ready = 1'b0;
    check("full_count", guess_count, 26);
    key_enter = 1'b1;
    repeat (D + 2) tick();
    check("full_dup", dup_flag, 1);
    key_enter = 1'b0;
    repeat (D + 4) tick();
    check("full_count_hold", guess_count, 26);

    // Random traffic
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      logic [2:0] keys;
      keys = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 10);
      key_up = keys[0];
      key_down = keys[1];
      key_enter = keys[2];
      for (int c = 0; c < hold; c++) begin
        guess_ready = ($urandom_range(0, 2) == 0);
        new_game    = ($urandom_range(0, 149) == 0);
        reset       = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    reset = 1'b0;
    new_game = 1'b0;
    key_up = 1'b0;
    key_down = 1'b0;
    key_enter = 1'b0;
    repeat (D + 4) tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
